// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch unit: PCSrc redirect codes and the fetch FSM states.
package pc_fetch_unit_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // A redirect is a valid execute-stage instruction with a branch/JAL or JALR code;
  // the reserved code 2'b11 behaves like sequential fetch.
  function automatic logic is_redirect(input logic ex_valid, input logic [1:0] pcsrc);
    return ex_valid & ((pcsrc == PCSRC_BR) | (pcsrc == PCSRC_JALR));
  endfunction

endpackage

// File: rtl/pc_fetch_unit_fifo.sv
// Response buffer between imem and decode: DEPTH entries of {instruction, pc},
// synchronous clear that overrides push/pop, occupancy count exported for credit.
module pc_fetch_unit_fifo
  import pc_fetch_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [31:0]                push_instr,
  input  logic [XLEN-1:0]            push_pc,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                head_instr,
  output logic [XLEN-1:0]            head_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;

  // Pointer and occupancy bookkeeping; clear wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents are only observed while counted as valid, so no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
    end
  end

  assign count      = cnt;
  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: owns the fetch PC, issues credit-limited in-order imem requests,
// tags responses with their PC and buffers them for decode. A taken redirect
// flushes the buffer and drops every response still in flight for the old path.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic [1:0]      pcsrc_i,
  input  logic [XLEN-1:0] pc_target_i,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_pcplus4_o,
  output logic            misalign_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic            misalign_q;
  logic [XLEN-1:0] pcq [DEPTH];
  logic [AW-1:0]   pcq_wr;
  logic [AW-1:0]   pcq_rd;

  logic [CW-1:0]   count;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [CW-1:0]   surviving;

  assign redirect  = is_redirect(ex_valid_i, pcsrc_i);
  assign req_valid = (state != ST_BOOT) & ~redirect &
                     (({1'b0, outstanding} + {1'b0, count}) < DEPTH_V);
  assign req_fire  = req_valid & imem_req_ready_i;
  assign rsp_drop  = imem_rsp_valid_i & (drop_cnt != '0);
  assign push      = imem_rsp_valid_i & ~rsp_drop & ~redirect;
  assign pop       = if_valid_o & if_ready_i & ~redirect;
  // Requests still owed a response after this cycle; all of them are stale on a redirect.
  assign surviving = outstanding - CW'(imem_rsp_valid_i);

  // Redirect target selection; JALR clears bit 0 of rs1+imm.
  always_comb begin
    target = pc_target_i;
    if (pcsrc_i == PCSRC_JALR) target = alu_result_i & ~XLEN'(1);
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_next;
  end

  // Fetch FSM next state: leave DRAIN once the last stale response is gone.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (redirect && surviving != '0) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (redirect)                                      state_next = ST_DRAIN;
        else if (drop_cnt == '0)                           state_next = ST_RUN;
        else if (drop_cnt == CW'(1) && rsp_drop)           state_next = ST_RUN;
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // Fetch PC, credit and drop counters, misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      misalign_q  <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid_i);
      misalign_q  <= redirect & target[1];
      if (redirect) begin
        fetch_pc <= target;
        drop_cnt <= surviving;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // PC tag queue pointers: written on request accept, read on every response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else begin
      if (req_fire)         pcq_wr <= pcq_wr + AW'(1);
      if (imem_rsp_valid_i) pcq_rd <= pcq_rd + AW'(1);
    end
  end

  // PC tag storage for in-flight requests.
  always_ff @(posedge clk) begin
    if (req_fire) pcq[pcq_wr] <= fetch_pc;
  end

  pc_fetch_unit_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (redirect),
    .push       (push),
    .push_instr (imem_rsp_data_i),
    .push_pc    (pcq[pcq_rd]),
    .pop        (pop),
    .count      (count),
    .head_instr (head_instr),
    .head_pc    (head_pc)
  );

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = fetch_pc;
  assign if_valid_o       = (count != '0);
  assign if_instr_o       = if_valid_o ? head_instr : '0;
  assign if_pc_o          = if_valid_o ? head_pc : '0;
  assign if_pcplus4_o     = if_valid_o ? (head_pc + XLEN'(4)) : '0;
  assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: imem model with configurable latency, request/response
// scoreboard, a redirect vector table and hand-written reset/drain sequences.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [1:0]  pcsrc;
  logic [31:0] pc_target;
  logic [31:0] alu_result;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pcplus4;
  logic        misalign;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid_i       (ex_valid),
    .pcsrc_i          (pcsrc),
    .pc_target_i      (pc_target),
    .alu_result_i     (alu_result),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .if_valid_o       (if_valid),
    .if_ready_i       (if_ready),
    .if_instr_o       (if_instr),
    .if_pc_o          (if_pc),
    .if_pcplus4_o     (if_pcplus4),
    .misalign_o       (misalign)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Scoreboard and imem model state (owned by the monitor process).
  typedef struct {
    int          due;
    logic [31:0] data;
  } imem_rsp_t;

  logic [31:0] exp_q[$];
  logic [31:0] exp_next_pc = RESET_PC;
  logic [31:0] log_pcs[$];
  imem_rsp_t   imem_q[$];
  int          fire_cnt = 0;
  int          cyc = 0;
  int          lat = 1;

  // Monitor + imem model, evaluated on the falling edge away from DUT updates.
  initial begin : monitor
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] e;
    imem_rsp_t   r;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        imem_q.delete();
        exp_next_pc = RESET_PC;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
      end else begin
        redir = ex_valid && (pcsrc == 2'b01 || pcsrc == 2'b10);
        tgt   = (pcsrc == 2'b01) ? pc_target : {alu_result[31:1], 1'b0};
        if (if_valid && if_ready && !redir) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_if_valid actual_pc=%h required=none", if_pc);
          end else begin
            e = exp_q.pop_front();
            check("if_pc", if_pc, e);
            check("if_instr", if_instr, ~e);
            check("if_pcplus4", if_pcplus4, e + 32'd4);
            log_pcs.push_back(if_pc);
          end
        end
        if (redir) begin
          check1("req_valid_in_redirect", req_valid, 1'b0);
          exp_q.delete();
          exp_next_pc = tgt;
        end else if (req_valid) begin
          check("req_addr", req_addr, exp_next_pc);
          if (req_ready) begin
            exp_q.push_back(exp_next_pc);
            exp_next_pc = exp_next_pc + 32'd4;
            fire_cnt++;
          end
        end
        rsp_valid = 1'b0;
        if (imem_q.size() > 0 && imem_q[0].due <= cyc) begin
          r         = imem_q.pop_front();
          rsp_valid = 1'b1;
          rsp_data  = r.data;
        end
        if (req_valid && req_ready)
          imem_q.push_back(imem_rsp_t'{due: cyc + lat, data: ~req_addr});
      end
    end
  end

  typedef struct {
    logic        ex;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
    logic        taken;
    logic [31:0] eff;
    logic        mis;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_two_outstanding(input string name);
    int n;
    n = 0;
    while (imem_q.size() != 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (imem_q.size() != 2) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=2", name, imem_q.size());
    end
  endtask

  task automatic wait_log(input string name, input int base, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (log_pcs.size() <= base && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (log_pcs.size() <= base) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=none required=%h", name, exp_pc);
    end else begin
      check(name, log_pcs[base], exp_pc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n    = 1'b0;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin : main
    int base;
    int fbase;
    vecs[0] = '{1'b1, 2'b01, 32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0};
    vecs[1] = '{1'b1, 2'b10, 32'hDEAD_0000, 32'h0000_0203, 1'b1, 32'h0000_0202, 1'b1};
    vecs[2] = '{1'b1, 2'b11, 32'h0000_8000, 32'h0000_8000, 1'b0, 32'h0000_8000, 1'b0};
    vecs[3] = '{1'b0, 2'b01, 32'h0000_9000, 32'h0000_0000, 1'b0, 32'h0000_9000, 1'b0};
    vecs[4] = '{1'b1, 2'b01, 32'h0000_0402, 32'h0000_0000, 1'b1, 32'h0000_0402, 1'b1};
    vecs[5] = '{1'b1, 2'b10, 32'hDEAD_0000, 32'h0000_0301, 1'b1, 32'h0000_0300, 1'b0};
    vecs[6] = '{1'b1, 2'b00, 32'h0000_A000, 32'h0000_A000, 1'b0, 32'h0000_A000, 1'b0};

    rst_n      = 1'b0;
    ex_valid   = 1'b0;
    pcsrc      = 2'b00;
    pc_target  = '0;
    alu_result = '0;
    req_ready  = 1'b1;
    if_ready   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check1("rst_req_valid", req_valid, 1'b0);
    check("rst_req_addr", req_addr, RESET_PC);
    check1("rst_if_valid", if_valid, 1'b0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_pcplus4", if_pcplus4, 32'h0);
    check1("rst_misalign", misalign, 1'b0);

    // Sequential stream from RESET_PC
    base  = log_pcs.size();
    rst_n = 1'b1;
    #1;
    check1("boot_req_valid", req_valid, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    if (log_pcs.size() < base + 3) begin
      checks++;
      errors++;
      $display("FAIL stream_count actual=%0d required>=3", log_pcs.size() - base);
    end else begin
      check("stream_pc0", log_pcs[base], 32'h0);
      check("stream_pc1", log_pcs[base + 1], 32'h4);
      check("stream_pc2", log_pcs[base + 2], 32'h8);
    end

    // Decode stalled: credit caps requests at DEPTH
    do_reset();
    if_ready = 1'b0;
    fbase    = fire_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("stall_req_count", 32'(fire_cnt - fbase), 32'd2);
    check1("stall_req_valid", req_valid, 1'b0);
    check1("stall_if_valid", if_valid, 1'b1);
    check("stall_if_pc", if_pc, RESET_PC);
    if_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Redirect with two outstanding requests: stale responses dropped
    lat = 3;
    wait_two_outstanding("drain");
    base      = log_pcs.size();
    ex_valid  = 1'b1;
    pcsrc     = 2'b01;
    pc_target = 32'h0000_0100;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    pcsrc    = 2'b00;
    check1("flush_if_valid", if_valid, 1'b0);
    check("flush_req_addr", req_addr, 32'h0000_0100);
    wait_log("drain_first_pc", base, 32'h0000_0100);
    lat = 1;
    repeat (6) @(posedge clk);
    #1;

    // Redirect vector table
    base = log_pcs.size();
    for (int i = 0; i < 7; i++) begin
      ex_valid   = vecs[i].ex;
      pcsrc      = vecs[i].src;
      pc_target  = vecs[i].tgt;
      alu_result = vecs[i].alu;
      @(posedge clk); #1;
      ex_valid = 1'b0;
      pcsrc    = 2'b00;
      check1($sformatf("vec%0d_taken", i), req_addr == vecs[i].eff, vecs[i].taken);
      check1($sformatf("vec%0d_misalign", i), misalign, vecs[i].mis);
      @(posedge clk); #1;
      check1($sformatf("vec%0d_misalign_off", i), misalign, 1'b0);
      repeat (4) @(posedge clk);
      #1;
    end
    checks++;
    if (log_pcs.size() < base + 7) begin
      errors++;
      $display("FAIL table_stream_count actual=%0d required>=7", log_pcs.size() - base);
    end

    // Reset while draining stale responses
    lat = 3;
    wait_two_outstanding("rst_drain");
    ex_valid  = 1'b1;
    pcsrc     = 2'b01;
    pc_target = 32'h0000_0502;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    pcsrc    = 2'b00;
    rst_n    = 1'b0;
    #1;
    check1("drst_req_valid", req_valid, 1'b0);
    check("drst_req_addr", req_addr, RESET_PC);
    check1("drst_if_valid", if_valid, 1'b0);
    check("drst_if_instr", if_instr, 32'h0);
    check("drst_if_pc", if_pc, 32'h0);
    check("drst_if_pcplus4", if_pcplus4, 32'h0);
    check1("drst_misalign", misalign, 1'b0);
    lat = 1;
    @(posedge clk); #1;
    base  = log_pcs.size();
    rst_n = 1'b1;
    wait_log("restart_first_pc", base, RESET_PC);
    repeat (6) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
